regfile_mp: RTL and testbench

Parametrised multi-port register file with two write ports, configurable read-port count, optional write-to-read bypass, hard-wired zero register and a per-register pending-write scoreboard. It is the general-purpose register file for the pipelined and dual-issue MIPS cores, sitting between decode (reads, reservations) and writeback (writes). Unlike the single-cycle file, its contents and scoreboard clear on reset.

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_scoreboard.sv | 49 ++++
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and constants for the multi-port register file
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int unsigned ZERO_ADDR = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write busy bits with set-over-clear priority
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD-1:0]        busy_raw,
  output logic                     busy_any
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Reservation is applied last so a new producer supersedes a completing one.
  always_comb begin
    busy_nxt = busy;
    if (we0) busy_nxt[wa0] = 1'b0;
    if (we1) busy_nxt[wa1] = 1'b0;
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[ZA] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_lookup
    assign busy_raw[i] = busy[ra[i*ADDR_W +: ADDR_W]];
  end

  assign busy_any = |busy;
endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-write, N-read register file with bypass, zero register and scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     busy_any
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);
  localparam bit ZR  = (ZERO_REG != 0);
  localparam bit BYP = (BYPASS != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_RD-1:0] busy_raw;

  logic wr0_ok, wr1_ok;
  assign wr0_ok = we0 && !(ZR && wa0 == ZA);
  assign wr1_ok = we1 && !(ZR && wa1 == ZA);

  // Port 1 is written second so it wins on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr0_ok) mem[wa0] <= wd0;
      if (wr1_ok) mem[wa1] <= wd1;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .we0      (we0),
    .wa0      (wa0),
    .we1      (we1),
    .wa1      (wa1),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .ra       (ra),
    .busy_raw (busy_raw),
    .busy_any (busy_any)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit0, hit1;
    logic [DATA_W-1:0] val;

    assign a = ra[i*ADDR_W +: ADDR_W];
    // Forwarding is held off in reset so reads show the cleared file.
    assign hit0 = BYP && rst_n && we0 && (wa0 == a);
    assign hit1 = BYP && rst_n && we1 && (wa1 == a);

    always_comb begin
      val = mem[a];
      if (ZR && a == ZA) val = '0;
      else if (hit1) val = wd1;
      else if (hit0) val = wd0;
    end

    assign rd[i*DATA_W +: DATA_W] = val;
    assign rd_busy[i] = busy_raw[i] && !(hit0 || hit1);
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench against a behavioural register file model
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we0, we1, rsv_en;
  logic [4:0]  wa0, wa1, rsv_addr;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra;
  logic [63:0] rd, rd_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        busy_any, busy_any_nb;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_mem [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_any(busy_any)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_nb), .rd_busy(rd_busy_nb),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_any(busy_any_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; rsv_en = 0;
    wa0 = '0; wa1 = '0; rsv_addr = '0;
    wd0 = '0; wd1 = '0;
  endtask

  // Expected outputs straight from the read/bypass/mask rules.
  task automatic compare_model();
    logic [31:0] e, e_nb;
    bit          b, b_nb, any;
    logic [4:0]  a;
    for (int p = 0; p < 2; p++) begin
      a = ra[p*5 +: 5];
      e_nb = (a == 0) ? 32'h0 : m_mem[a];
      e = e_nb;
      b_nb = m_busy[a];
      b = b_nb;
      if (a != 0 && rst_n) begin
        if (we1 && wa1 == a) e = wd1;
        else if (we0 && wa0 == a) e = wd0;
      end
      if (rst_n && ((we0 && wa0 == a) || (we1 && wa1 == a))) b = 1'b0;
      check($sformatf("rd%0d", p), rd[p*32 +: 32], e);
      check($sformatf("rd_nb%0d", p), rd_nb[p*32 +: 32], e_nb);
      check($sformatf("rd_busy%0d", p), {31'b0, rd_busy[p]}, {31'b0, b});
      check($sformatf("rd_busy_nb%0d", p), {31'b0, rd_busy_nb[p]}, {31'b0, b_nb});
    end
    any = 1'b0;
    for (int r = 0; r < 32; r++) any |= m_busy[r];
    check("busy_any", {31'b0, busy_any}, {31'b0, any});
    check("busy_any_nb", {31'b0, busy_any_nb}, {31'b0, any});
  endtask

  task automatic model_edge();
    logic [31:0] nm [32];
    bit          nb [32];
    for (int r = 0; r < 32; r++) begin
      nm[r] = m_mem[r];
      if (r != 0 && we1 && wa1 == r) nm[r] = wd1;
      else if (r != 0 && we0 && wa0 == r) nm[r] = wd0;
      if (r != 0 && rsv_en && rsv_addr == r) nb[r] = 1'b1;
      else if ((we0 && wa0 == r) || (we1 && wa1 == r)) nb[r] = 1'b0;
      else nb[r] = m_busy[r];
    end
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = nm[r];
      m_busy[r] = nb[r];
    end
  endtask

  task automatic step();
    #1;
    compare_model();
    @(posedge clk);
    #0;
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_rd0", rd[31:0], 32'h0);
    check("rst_rd1", rd[63:32], 32'h0);
    check("rst_busy", {30'b0, rd_busy}, 32'h0);
    check("rst_any", {31'b0, busy_any}, 32'h0);
    compare_model();
    @(posedge clk);
    @(negedge clk);
    compare_model();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    ra = '0;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    step();
    rst_n = 1'b1;

    // Dual write to r5: port 1 wins.
    we0 = 1; wa0 = 5; wd0 = 32'h1111_1111;
    we1 = 1; wa1 = 5; wd1 = 32'h2222_2222;
    ra = {5'd0, 5'd5};
    step();
    idle();
    #1 check("dual_wr", rd[31:0], 32'h2222_2222);
    step();

    // Zero register ignores writes and reservations.
    we0 = 1; wa0 = 0; wd0 = 32'hDEAD_BEEF;
    rsv_en = 1; rsv_addr = 0;
    ra = {5'd0, 5'd0};
    step();
    idle();
    #1 check("zero_rd", rd[31:0], 32'h0);
    check("zero_any", {31'b0, busy_any}, 32'h0);
    step();

    // Bypass versus registered read on port 1.
    we1 = 1; wa1 = 7; wd1 = 32'h0000_00AB;
    ra = {5'd7, 5'd0};
    #1 check("byp_same", rd[63:32], 32'h0000_00AB);
    check("nobyp_same", rd_nb[63:32], 32'h0);
    step();
    idle();
    #1 check("nobyp_next", rd_nb[63:32], 32'h0000_00AB);
    step();

    // Reserve r9, then complete it.
    rsv_en = 1; rsv_addr = 9; ra = {5'd0, 5'd9};
    step();
    idle();
    #1 check("rsv_vis", {31'b0, rd_busy[0]}, 32'h1);
    step();
    we0 = 1; wa0 = 9; wd0 = 32'h9999_0009;
    #1 check("rsv_mask", {31'b0, rd_busy[0]}, 32'h0);
    check("rsv_nomask", {31'b0, rd_busy_nb[0]}, 32'h1);
    step();
    idle();
    #1 check("rsv_clear_any", {31'b0, busy_any}, 32'h0);
    step();

    // Simultaneous reserve and write on r12.
    rsv_en = 1; rsv_addr = 12; we0 = 1; wa0 = 12; wd0 = 32'h1212_1212;
    ra = {5'd0, 5'd12};
    step();
    idle();
    #1 check("rsvwr_busy", {31'b0, rd_busy[0]}, 32'h1);
    check("rsvwr_data", rd[31:0], 32'h1212_1212);
    step();

    for (int n = 0; n < 600; n++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      rsv_en = ($urandom_range(0, 2) == 0);
      wa0 = 5'($urandom_range(0, 15));
      wa1 = 5'($urandom_range(0, 15));
      rsv_addr = 5'($urandom_range(0, 15));
      wd0 = $urandom;
      wd1 = $urandom;
      ra = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      if (n % 150 == 149) mid_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
